// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// op encodings, FSM state codes and iteration count.
package mips_pkg;

    typedef logic [1:0] md_op_t;

    localparam md_op_t MD_MULT  = 2'b00;
    localparam md_op_t MD_MULTU = 2'b01;
    localparam md_op_t MD_DIV   = 2'b10;
    localparam md_op_t MD_DIVU  = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int unsigned MD_ITER = 32;

    // Low op bit clear selects the signed variants (MULT, DIV).
    function automatic logic md_is_signed(input md_op_t op);
        return !op[0];
    endfunction

    function automatic logic md_is_div(input md_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Start/busy/done handshake and result bus between the control unit and
// the multiply/divide unit.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add for multiply, restoring
// shift-subtract for divide. Purely combinational.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH:0]     rem,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [WIDTH:0]     rem_next
);
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        shifted = {rem[WIDTH-1:0], acc[WIDTH-1]};
        // rem < divisor keeps a non-negative diff below 2^WIDTH, so the top bit is the borrow.
        diff    = shifted - {1'b0, operand};

        if (is_div) begin
            rem_next = diff[WIDTH] ? shifted : diff;
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            rem_next = rem;
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// 32 CALC cycles, one FIX cycle for sign correction, one DONE pulse.
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input logic                clk,
    input logic                reset,
    muldiv_sequencer_if.slave  bus
);
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic               neg_a_q, neg_b_q, b_zero_q;
    logic [WIDTH-1:0]   a_raw_q, opnd_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               dbz_q;
    logic [2*WIDTH-1:0] acc_q, acc_step;
    logic [WIDTH:0]     rem_q, rem_step;

    logic               accept;
    logic               sgn_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rmd;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign accept = bus.start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        sgn_op = md_is_signed(bus.op);
        a_mag  = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag  = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: if (cnt_q == CNT_W'(MD_ITER - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = accept ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div   (md_is_div(op_q)),
        .acc      (acc_q),
        .rem      (rem_q),
        .operand  (opnd_q),
        .acc_next (acc_step),
        .rem_next (rem_step)
    );

    // Sign fix-up; the sign flags are already zero for the unsigned ops.
    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rmd  = neg_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        if (md_is_div(op_q)) begin
            if (b_zero_q) begin
                fix_hi = a_raw_q;
                fix_lo = '1;
            end else begin
                fix_hi = rmd;
                fix_lo = quo;
            end
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= MD_MULT;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            a_raw_q  <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q    <= '0;
                op_q     <= bus.op;
                neg_a_q  <= sgn_op && bus.a[WIDTH-1];
                neg_b_q  <= sgn_op && bus.b[WIDTH-1];
                b_zero_q <= (bus.b == '0);
                a_raw_q  <= bus.a;
                rem_q    <= '0;
                dbz_q    <= 1'b0;
                // Divide iterates over the dividend; multiply over the multiplier.
                if (md_is_div(bus.op)) begin
                    opnd_q <= b_mag;
                    acc_q  <= {{WIDTH{1'b0}}, a_mag};
                end else begin
                    opnd_q <= a_mag;
                    acc_q  <= {{WIDTH{1'b0}}, b_mag};
                end
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + 1'b1;
                acc_q <= acc_step;
                rem_q <= rem_step;
            end else if (state_q == FIX) begin
                hi_q  <= fix_hi;
                lo_q  <= fix_lo;
                dbz_q <= md_is_div(op_q) && b_zero_q;
            end
        end
    end

    assign bus.busy        = (state_q == CALC) || (state_q == FIX);
    assign bus.done        = (state_q == DONE);
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, signed/unsigned results,
// divide-by-zero, overflow, ignored starts and mid-operation reset.
module tb_muldiv_sequencer;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present start before an edge; return #1 after the accepting edge.
    task automatic launch(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done, bounded at 60.
    // pre_hi/pre_lo are the values seen in the last cycle before done.
    task automatic wait_done(output int lat, output int busy_n,
                             output logic [31:0] pre_hi, output logic [31:0] pre_lo);
        lat    = 0;
        busy_n = bus.busy ? 1 : 0;
        pre_hi = bus.hi;
        pre_lo = bus.lo;
        while (!bus.done && lat < 60) begin
            pre_hi = bus.hi;
            pre_lo = bus.lo;
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) busy_n++;
        end
    endtask

    int          lat, busy_n, dones;
    logic [31:0] ph, pl, got_hi, got_lo;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = MD_MULT;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // done follows the 33rd edge after the accepting edge (34 counting it)
        launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, busy_n, ph, pl);
        chk("multu_lat", 32'(lat), 32'd33);
        chk("multu_busy_cycles", 32'(busy_n), 32'd33);
        chk("multu_hi_held", ph, 32'h0);
        chk("multu_lo_held", pl, 32'h0);
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);
        chk("multu_dbz", 32'(bus.div_by_zero), 32'd0);
        @(posedge clk);
        #1;
        chk("done_pulse_width", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_hi_hold", bus.hi, 32'hFFFF_FFFE);

        launch(MD_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, busy_n, ph, pl);
        chk("mult_lat", 32'(lat), 32'd33);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFEB);

        // back-to-back: start presented in the DONE cycle
        launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(lat, busy_n, ph, pl);
        chk("div_lat", 32'(lat), 32'd33);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);

        launch(MD_DIVU, 32'd100, 32'd0);
        wait_done(lat, busy_n, ph, pl);
        chk("dz_lat", 32'(lat), 32'd33);
        chk("dz_hi", bus.hi, 32'd100);
        chk("dz_lo", bus.lo, 32'hFFFF_FFFF);
        chk("dz_flag", 32'(bus.div_by_zero), 32'd1);
        @(posedge clk);
        #1;
        chk("dz_sticky", 32'(bus.div_by_zero), 32'd1);

        launch(MD_MULTU, 32'd2, 32'd3);
        chk("dz_cleared_on_accept", 32'(bus.div_by_zero), 32'd0);
        wait_done(lat, busy_n, ph, pl);
        chk("m23_lo", bus.lo, 32'd6);
        chk("m23_hi", bus.hi, 32'd0);
        chk("m23_dbz", 32'(bus.div_by_zero), 32'd0);

        launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, busy_n, ph, pl);
        chk("ovf_lo", bus.lo, 32'h8000_0000);
        chk("ovf_hi", bus.hi, 32'h0);
        chk("ovf_dbz", 32'(bus.div_by_zero), 32'd0);

        launch(MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, busy_n, ph, pl);
        chk("divu_big_lo", bus.lo, 32'h0);
        chk("divu_big_hi", bus.hi, 32'h8000_0000);

        // starts while busy, with operands changed, must be ignored
        launch(MD_MULTU, 32'd5, 32'd9);
        dones  = 0;
        got_hi = 32'hDEAD_BEEF;
        got_lo = 32'hDEAD_BEEF;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                got_hi = bus.hi;
                got_lo = bus.lo;
            end
            bus.start = (i == 5 || i == 10);
            if (i == 5 || i == 10) begin
                bus.op = MD_DIV;
                bus.a  = 32'h1234_5678 + 32'(i);
                bus.b  = 32'h11;
            end
        end
        chk("ign_dones", 32'(dones), 32'd1);
        chk("ign_lo", got_lo, 32'd45);
        chk("ign_hi", got_hi, 32'd0);

        // reset while the counter reads 15
        launch(MD_DIVU, 32'd1000, 32'd7);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_hi", bus.hi, 32'h0);
        chk("abort_lo", bus.lo, 32'h0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);

        launch(MD_DIVU, 32'd1000, 32'd7);
        wait_done(lat, busy_n, ph, pl);
        chk("d1000_lat", 32'(lat), 32'd33);
        chk("d1000_lo", bus.lo, 32'd142);
        chk("d1000_hi", bus.hi, 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
